// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the core memory port and data_mem_ctrl.
interface data_mem_ctrl_if;
   logic        valid_i;
   logic        wen_i;
   logic [31:0] addr_i;
   logic [31:0] write_data_i;
   logic [3:0]  mask_i;
   logic        yumi_o;
   logic        valid_o;
   logic [31:0] read_data_o;
   logic        busy_o;
   logic        error_o;

   modport master (
      output valid_i, wen_i, addr_i, write_data_i, mask_i,
      input  yumi_o, valid_o, read_data_o, busy_o, error_o
   );

   modport slave (
      input  valid_i, wen_i, addr_i, write_data_i, mask_i,
      output yumi_o, valid_o, read_data_o, busy_o, error_o
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a fixed response latency for the core's memory port.
// Optional out-of-range detection is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_ctrl #(
   parameter int unsigned addr_width_p = 10,
   parameter int unsigned latency_p    = 2
) (
   input  logic           clk,
   input  logic           reset,
   data_mem_ctrl_if.slave bus
);

   localparam int unsigned depth_lp   = 1 << addr_width_p;
   localparam int unsigned data_w_lp  = 32;
   localparam int unsigned cnt_w_lp   = 4;
   localparam int unsigned bytes_lp   = data_w_lp / 8;

   localparam logic [1:0] st_idle = 2'd0;
   localparam logic [1:0] st_wait = 2'd1;
   localparam logic [1:0] st_resp = 2'd2;

   logic [data_w_lp-1:0] mem [depth_lp];

   logic [1:0]              state_q, state_d;
   logic [cnt_w_lp-1:0]     cnt_q, cnt_d;
   logic [data_w_lp-1:0]    rdata_q, rdata_d;
   logic                    oob_q, oob_d;
   logic                    error_q, error_d;

   logic [addr_width_p-1:0] word_idx_c;
   logic                    accept_c;
   logic                    oob_c;
   logic                    unused_addr_bits_c;

   assign word_idx_c = bus.addr_i[addr_width_p+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
   assign oob_c              = |bus.addr_i[31:addr_width_p+2];
   assign unused_addr_bits_c = ^bus.addr_i[1:0];
`else
   // Upper address bits wrap onto the array.
   assign oob_c              = 1'b0;
   assign unused_addr_bits_c = ^{bus.addr_i[31:addr_width_p+2], bus.addr_i[1:0]};
`endif

   assign accept_c = bus.valid_i & ~reset & ((state_q == st_idle) | (state_q == st_resp));

   // State and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= st_idle;
         cnt_q   <= '0;
         rdata_q <= '0;
         oob_q   <= 1'b0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         oob_q   <= oob_d;
         error_q <= error_d;
      end
   end

   // Next-state logic; a new accept overrides the RESP->IDLE return.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      oob_d   = oob_q;
      error_d = error_q;

      case (state_q)
         st_wait: begin
            cnt_d = cnt_q - cnt_w_lp'(1);
            if (cnt_q == cnt_w_lp'(1)) state_d = st_resp;
         end
         st_resp: state_d = st_idle;
         default: state_d = st_idle;
      endcase

      if (accept_c) begin
         oob_d = oob_c;
         if (latency_p == 1) begin
            state_d = st_resp;
            cnt_d   = '0;
         end else begin
            state_d = st_wait;
            cnt_d   = cnt_w_lp'(latency_p - 1);
         end
         if (bus.wen_i)  rdata_d = '0;
         else if (oob_c) rdata_d = 32'hDEAD_BEEF;
         else            rdata_d = mem[word_idx_c];
      end

      if ((state_d == st_resp) && oob_d) error_d = 1'b1;
   end

   // Byte-masked store, committed only on an accepting, in-range edge.
   always_ff @(posedge clk) begin
      if (accept_c && bus.wen_i && !oob_c) begin
         for (int b = 0; b < int'(bytes_lp); b++) begin
            if (bus.mask_i[b]) mem[word_idx_c][8*b +: 8] <= bus.write_data_i[8*b +: 8];
         end
      end
   end

   assign bus.yumi_o      = accept_c;
   assign bus.valid_o     = (state_q == st_resp);
   assign bus.read_data_o = (state_q == st_resp) ? rdata_q : '0;
   assign bus.busy_o      = (state_q != st_idle);
   assign bus.error_o     = error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed plus randomized checks of data_mem_ctrl against an array-based reference model.
module tb_data_mem_ctrl;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [31:0] model_mem [1024];
   logic        err_exp;

   data_mem_ctrl_if bus2();
   data_mem_ctrl_if bus1();

   data_mem_ctrl #(.addr_width_p(10), .latency_p(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
   data_mem_ctrl #(.addr_width_p(10), .latency_p(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic is_oob(input logic [31:0] addr);
`ifdef DMEM_BOUNDS_CHECK_EN
      return addr[31:12] != 20'd0;
`else
      return 1'b0;
`endif
   endfunction

   // One request on the latency-2 instance; model updates at the accepting edge.
   task automatic req2(input logic wen, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] mask, input string tag);
      int          n;
      int          idx;
      logic [31:0] exp;
      logic        oob;
      bus2.valid_i      = 1'b1;
      bus2.wen_i        = wen;
      bus2.addr_i       = addr;
      bus2.write_data_i = data;
      bus2.mask_i       = mask;
      #1;
      n = 0;
      while (!bus2.yumi_o && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({tag, " accept"}, 32'(bus2.yumi_o), 32'd1);
      idx = int'(addr[11:2]);
      oob = is_oob(addr);
      if (wen) begin
         exp = 32'd0;
         if (!oob)
            for (int b = 0; b < 4; b++)
               if (mask[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
      end else begin
         exp = oob ? 32'hDEAD_BEEF : model_mem[idx];
      end
      if (oob) err_exp = 1'b1;
      @(negedge clk);
      bus2.valid_i = 1'b0;
      chk({tag, " busy"}, 32'(bus2.busy_o), 32'd1);
      n = 1;
      while (!bus2.valid_o && n < 20) begin
         @(negedge clk); n++;
      end
      chk({tag, " latency"}, 32'(n), 32'd2);
      chk({tag, " data"}, bus2.read_data_o, exp);
      chk({tag, " error"}, 32'(bus2.error_o), 32'(err_exp));
      @(negedge clk);
      chk({tag, " idle"}, {bus2.read_data_o[30:0], bus2.busy_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] a, d, upper;
      logic [3:0]  m;
      logic        w;
      logic [31:0] exp_a, exp_b;
      checks   = 0;
      failures = 0;
      err_exp  = 1'b0;
      reset    = 1'b1;
      bus2.valid_i = 1'b1; bus2.wen_i = 1'b0; bus2.addr_i = '0; bus2.write_data_i = '0; bus2.mask_i = '0;
      bus1.valid_i = 1'b0; bus1.wen_i = 1'b0; bus1.addr_i = '0; bus1.write_data_i = '0; bus1.mask_i = '0;

      // Reset state, with a request presented that must be refused.
      repeat (3) @(negedge clk);
      chk("rst yumi", 32'(bus2.yumi_o), 32'd0);
      chk("rst valid", 32'(bus2.valid_o), 32'd0);
      chk("rst busy", 32'(bus2.busy_o), 32'd0);
      chk("rst rdata", bus2.read_data_o, 32'd0);
      chk("rst error", 32'(bus2.error_o), 32'd0);
      bus2.valid_i = 1'b0;
      reset = 1'b0;
      @(negedge clk);

      // Fill the low words so every later load has a defined expectation.
      for (int i = 0; i < 16; i++) req2(1'b1, 32'(i * 4), $urandom, 4'hF, "init");

      req2(1'b1, 32'h10, 32'h1234_5678, 4'hF, "t1 store");
      req2(1'b0, 32'h10, 32'h0, 4'h0, "t1 load");
      req2(1'b1, 32'h20, 32'hAABB_CCDD, 4'hF, "t2 store full");
      req2(1'b1, 32'h20, 32'h0000_1100, 4'b0010, "t2 store byte1");
      req2(1'b0, 32'h23, 32'h0, 4'h0, "t2 load");
      chk("t2 value", model_mem[8], 32'hAABB_11DD);

      // Back-to-back on the latency-1 instance with valid held high.
      @(negedge clk);
      bus1.valid_i = 1'b1; bus1.wen_i = 1'b1; bus1.addr_i = 32'h0;
      bus1.write_data_i = 32'h1111_1111; bus1.mask_i = 4'hF;
      #1 chk("t3 yumi0", 32'(bus1.yumi_o), 32'd1);
      @(negedge clk);
      bus1.addr_i = 32'h4; bus1.write_data_i = 32'h2222_2222;
      #1 chk("t3 yumi1", {bus1.yumi_o, bus1.valid_o}, 32'd3);
      chk("t3 rd store", bus1.read_data_o, 32'd0);
      @(negedge clk);
      bus1.wen_i = 1'b0; bus1.addr_i = 32'h0;
      #1 chk("t3 yumi2", {bus1.yumi_o, bus1.valid_o}, 32'd3);
      @(negedge clk);
      bus1.addr_i = 32'h4;
      #1 chk("t3 yumi3", {bus1.yumi_o, bus1.valid_o}, 32'd3);
      chk("t3 rd w0", bus1.read_data_o, 32'h1111_1111);
      @(negedge clk);
      bus1.valid_i = 1'b0;
      #1 chk("t3 rd w1", bus1.read_data_o, 32'h2222_2222);
      chk("t3 valid last", 32'(bus1.valid_o), 32'd1);
      @(negedge clk);
      chk("t3 drained", {bus1.valid_o, bus1.busy_o}, 32'd0);

      // Request held during WAIT is taken in the RESP cycle.
      exp_a = model_mem[4];
      exp_b = model_mem[8];
      bus2.valid_i = 1'b1; bus2.wen_i = 1'b0; bus2.addr_i = 32'h10;
      #1 chk("t4 acc A", 32'(bus2.yumi_o), 32'd1);
      @(negedge clk);
      bus2.addr_i = 32'h20;
      #1 chk("t4 wait yumi", {bus2.yumi_o, bus2.valid_o}, 32'd0);
      @(negedge clk);
      #1 chk("t4 resp A", {bus2.yumi_o, bus2.valid_o}, 32'd3);
      chk("t4 data A", bus2.read_data_o, exp_a);
      @(negedge clk);
      bus2.valid_i = 1'b0;
      chk("t4 wait B", {bus2.valid_o, bus2.busy_o}, 32'd1);
      chk("t4 wait rd", bus2.read_data_o, 32'd0);
      @(negedge clk);
      chk("t4 resp B", 32'(bus2.valid_o), 32'd1);
      chk("t4 data B", bus2.read_data_o, exp_b);
      @(negedge clk);
      chk("t4 idle", 32'(bus2.busy_o), 32'd0);

      // Reset during WAIT discards the response; a store in reset is not committed.
      bus2.valid_i = 1'b1; bus2.wen_i = 1'b0; bus2.addr_i = 32'h10;
      #1 chk("t5 acc", 32'(bus2.yumi_o), 32'd1);
      @(negedge clk);
      bus2.valid_i = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      bus2.valid_i = 1'b1; bus2.wen_i = 1'b1; bus2.write_data_i = 32'h0; bus2.mask_i = 4'hF;
      #1 chk("t5 rst yumi", 32'(bus2.yumi_o), 32'd0);
      @(negedge clk);
      bus2.valid_i = 1'b0;
      reset = 1'b0;
      err_exp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t5 no resp", {bus2.valid_o, bus2.busy_o}, 32'd0);
         @(negedge clk);
      end
      req2(1'b0, 32'h10, 32'h0, 4'h0, "t5 load");

      // Upper address bits: alias to word 0 or flagged, depending on build.
      req2(1'b1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, "t6 store");
      req2(1'b0, 32'h0000_1000, 32'h0, 4'h0, "t6 load hi");
      req2(1'b0, 32'h0000_0000, 32'h0, 4'h0, "t6 load w0");

      // Randomized traffic over the low 16 words, sometimes with upper bits set.
      for (int i = 0; i < 150; i++) begin
         upper = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 1023)) : 32'd0;
         a = (upper << 12) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         w = 1'($urandom_range(0, 1));
         req2(w, a, d, m, "rand");
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
